mock_gamepad_multi: RTL and testbench

Parametrised, multi-player simulation/board-test model of a serial gamepad port, replacing the single-player 12-button mock. It presents `PLAYERS` independent serial data lines, each driven by a `BUTTONS`-bit parallel latched shift register, to the design's gamepad reader. Compared with the single-player mock it adds:
- synchronised, edge-detected `pad_clk` and `pad_latch`
- configurable line polarity and post-read fill
- per-player connect masking
- read-progress and latch-count status for benches

---
 rtl/mock_gamepad_multi_if.sv | 22 ++
 rtl/mock_gamepad_multi.sv | 59 +++++
 tb/tb_mock_gamepad_multi.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mock_gamepad_multi_if.sv
// mock_gamepad_multi_if: serial gamepad port bundle between a reader (master) and the mock pad (slave)
interface mock_gamepad_multi_if #(
  parameter int PLAYERS = 2,
  parameter int BUTTONS = 12
);
  logic [PLAYERS*BUTTONS-1:0] pad_btn;
  logic [PLAYERS-1:0] pad_connected;
  logic pad_clk;
  logic pad_latch;
  logic [PLAYERS-1:0] pad_out;
  logic [$clog2(BUTTONS+1)-1:0] bits_read;
  logic read_done;
  logic [15:0] latch_count;
  modport master(
    output pad_btn, pad_connected, pad_clk, pad_latch,
    input pad_out, bits_read, read_done, latch_count
  );
  modport slave(
    input pad_btn, pad_connected, pad_clk, pad_latch,
    output pad_out, bits_read, read_done, latch_count
  );
endinterface

// File: rtl/mock_gamepad_multi.sv
// mock_gamepad_multi: multi-player latched shift-register gamepad model with synchronised pad_clk/pad_latch
module mock_gamepad_multi #(
  parameter int PLAYERS = 2,
  parameter int BUTTONS = 12,
  parameter int ACTIVE_LOW = 1,
  parameter int FILL_BIT = 1
) (
  input logic clk,
  input logic reset,
  mock_gamepad_multi_if.slave bus
);
  localparam int BW = $clog2(BUTTONS + 1);
  localparam logic REL = ACTIVE_LOW[0];
  localparam logic [BUTTONS-1:0] RELEASED = {BUTTONS{REL}};
  localparam logic [BUTTONS-1:0] ONE = 1;
  localparam logic [BUTTONS-1:0] FILL_MSB = FILL_BIT[0] ? ONE << (BUTTONS - 1) : '0;
  localparam logic [BW-1:0] FULL = BW'(BUTTONS);
  logic [2:0] cs, ls;
  logic [PLAYERS-1:0][BUTTONS-1:0] sr;
  logic [BW-1:0] cnt;
  logic full_q, done;
  logic [15:0] lc;
  logic clk_rise, latch_fall, latch_hi;
  assign clk_rise = cs[1] & ~cs[2];
  assign latch_fall = ls[2] & ~ls[1];
  assign latch_hi = ls[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      cs <= '0;
      ls <= '0;
      sr <= {PLAYERS{RELEASED}};
      cnt <= '0;
      full_q <= 1'b0;
      done <= 1'b0;
      lc <= '0;
    end else begin
      cs <= {cs[1:0], bus.pad_clk};
      ls <= {ls[1:0], bus.pad_latch};
      // done is registered from the transition into FULL, so it lands one edge after bits_read
      full_q <= cnt == FULL;
      done <= (cnt == FULL) && !full_q;
      if (latch_fall) lc <= lc + 16'd1;
      if (latch_hi) begin
        for (int p = 0; p < PLAYERS; p++) sr[p] <= bus.pad_btn[p*BUTTONS +: BUTTONS] ^ RELEASED;
        cnt <= '0;
      end else if (clk_rise) begin
        for (int p = 0; p < PLAYERS; p++) sr[p] <= (sr[p] >> 1) | FILL_MSB;
        cnt <= (cnt == FULL) ? cnt : cnt + 1'b1;
      end
    end
  end
  always_comb begin
    bus.pad_out = '0;
    for (int p = 0; p < PLAYERS; p++) bus.pad_out[p] = bus.pad_connected[p] ? sr[p][0] : REL;
  end
  assign bus.bits_read = cnt;
  assign bus.read_done = done;
  assign bus.latch_count = lc;
endmodule

// File: tb/tb_mock_gamepad_multi.sv
// tb_mock_gamepad_multi: randomized reads of the mock gamepad checked against a per-bit line model
module tb_mock_gamepad_multi;
  localparam int PLAYERS = 2;
  localparam int BUTTONS = 12;
  localparam int ACTIVE_LOW = 1;
  localparam int FILL_BIT = 1;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mock_gamepad_multi_if #(.PLAYERS(PLAYERS), .BUTTONS(BUTTONS)) bus();
  mock_gamepad_multi #(.PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .ACTIVE_LOW(ACTIVE_LOW), .FILL_BIT(FILL_BIT))
    dut (.clk(clk), .reset(reset), .bus(bus));
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int lc_model = 0;
  logic [PLAYERS-1:0] got [0:40];
  int br [0:40];
  int dn [0:40];
  logic [BUTTONS-1:0] exp_btn [PLAYERS];
  always @(posedge clk) if (bus.read_done === 1'b1) done_cnt++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  // Expected line level for bit i of a read, from the button snapshot taken at latch time
  function automatic logic exp_line(input logic [BUTTONS-1:0] b, input int i, input logic conn);
    if (!conn) return 1'(ACTIVE_LOW);
    return (i < BUTTONS) ? (b[i] ^ 1'(ACTIVE_LOW)) : 1'(FILL_BIT);
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_latch();
    bus.pad_latch = 1'b1;
    cyc(4);
    for (int p = 0; p < PLAYERS; p++) exp_btn[p] = bus.pad_btn[p*BUTTONS +: BUTTONS];
    bus.pad_latch = 1'b0;
    cyc(5);
    lc_model++;
  endtask
  task automatic shift_read(input int n);
    got[0] = bus.pad_out;
    br[0] = int'(bus.bits_read);
    dn[0] = done_cnt;
    for (int k = 1; k <= n; k++) begin
      bus.pad_clk = 1'b1;
      cyc(4);
      bus.pad_clk = 1'b0;
      cyc(4);
      got[k] = bus.pad_out;
      br[k] = int'(bus.bits_read);
      dn[k] = done_cnt;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.pad_clk = 1'b0;
    bus.pad_latch = 1'b0;
    bus.pad_connected = 2'b11;
    bus.pad_btn = '0;
    cyc(2);
    reset = 1'b0;
    n_checks++;
    if (bus.pad_out !== 2'b11) begin n_fail++; $display("FAIL reset pad_out got %b want 11", bus.pad_out); end
    n_checks++;
    if (bus.bits_read !== 4'd0) begin n_fail++; $display("FAIL reset bits_read got %0d want 0", bus.bits_read); end
    n_checks++;
    if (bus.latch_count !== 16'd0) begin n_fail++; $display("FAIL reset latch_count got %0d want 0", bus.latch_count); end
    n_checks++;
    if (bus.read_done !== 1'b0) begin n_fail++; $display("FAIL reset read_done got %b want 0", bus.read_done); end
    cyc(2);
  endtask
  task automatic test_basic_read();
    bus.pad_btn = {12'h001, 12'h5A3};
    pulse_latch();
    shift_read(12);
    for (int i = 0; i < 12; i++)
      for (int p = 0; p < PLAYERS; p++) begin
        n_checks++;
        if (got[i][p] !== exp_line(exp_btn[p], i, 1'b1)) begin
          n_fail++; $display("FAIL basic bit%0d p%0d got %b want %b", i, p, got[i][p], exp_line(exp_btn[p], i, 1'b1));
        end
      end
    for (int k = 0; k <= 12; k++) begin
      n_checks++;
      if (br[k] != k) begin n_fail++; $display("FAIL basic bits_read after %0d got %0d want %0d", k, br[k], k); end
    end
    n_checks++;
    if (dn[11] - dn[0] != 0) begin n_fail++; $display("FAIL basic early read_done got %0d want 0", dn[11] - dn[0]); end
    n_checks++;
    if (dn[12] - dn[0] != 1) begin n_fail++; $display("FAIL basic read_done count got %0d want 1", dn[12] - dn[0]); end
    n_checks++;
    if (int'(bus.latch_count) != lc_model) begin n_fail++; $display("FAIL basic latch_count got %0d want %0d", bus.latch_count, lc_model); end
  endtask
  task automatic test_over_read();
    pulse_latch();
    shift_read(16);
    for (int i = 0; i <= 16; i++)
      for (int p = 0; p < PLAYERS; p++) begin
        n_checks++;
        if (got[i][p] !== exp_line(exp_btn[p], i, 1'b1)) begin
          n_fail++; $display("FAIL over bit%0d p%0d got %b want %b", i, p, got[i][p], exp_line(exp_btn[p], i, 1'b1));
        end
      end
    n_checks++;
    if (br[16] != BUTTONS) begin n_fail++; $display("FAIL over bits_read got %0d want %0d", br[16], BUTTONS); end
    n_checks++;
    if (dn[16] - dn[0] != 1) begin n_fail++; $display("FAIL over read_done count got %0d want 1", dn[16] - dn[0]); end
  endtask
  task automatic test_random_reads();
    for (int r = 0; r < 4; r++) begin
      bus.pad_btn = 24'($urandom);
      bus.pad_connected = 2'($urandom_range(0, 3));
      pulse_latch();
      shift_read(13);
      for (int i = 0; i <= 13; i++)
        for (int p = 0; p < PLAYERS; p++) begin
          n_checks++;
          if (got[i][p] !== exp_line(exp_btn[p], i, bus.pad_connected[p])) begin
            n_fail++; $display("FAIL random r%0d bit%0d p%0d got %b want %b", r, i, p, got[i][p], exp_line(exp_btn[p], i, bus.pad_connected[p]));
          end
        end
      n_checks++;
      if (dn[13] - dn[0] != 1) begin n_fail++; $display("FAIL random r%0d read_done count got %0d want 1", r, dn[13] - dn[0]); end
    end
    bus.pad_connected = 2'b11;
  endtask
  task automatic test_latch_priority();
    bus.pad_btn = {12'h0F0, 12'h00F};
    bus.pad_latch = 1'b1;
    cyc(4);
    for (int t = 0; t < 5; t++) begin
      if (t == 2) bus.pad_btn[11:0] = 12'h800;
      bus.pad_clk = 1'b1;
      cyc(4);
      bus.pad_clk = 1'b0;
      cyc(4);
      n_checks++;
      if (bus.bits_read !== 4'd0) begin n_fail++; $display("FAIL prio bits_read toggle%0d got %0d want 0", t, bus.bits_read); end
    end
    for (int p = 0; p < PLAYERS; p++) exp_btn[p] = bus.pad_btn[p*BUTTONS +: BUTTONS];
    bus.pad_latch = 1'b0;
    cyc(5);
    lc_model++;
    shift_read(12);
    n_checks++;
    if (got[0][0] !== 1'b1) begin n_fail++; $display("FAIL prio first bit p0 got %b want 1", got[0][0]); end
    for (int i = 0; i < 12; i++)
      for (int p = 0; p < PLAYERS; p++) begin
        n_checks++;
        if (got[i][p] !== exp_line(exp_btn[p], i, 1'b1)) begin
          n_fail++; $display("FAIL prio bit%0d p%0d got %b want %b", i, p, got[i][p], exp_line(exp_btn[p], i, 1'b1));
        end
      end
    n_checks++;
    if (int'(bus.latch_count) != lc_model) begin n_fail++; $display("FAIL prio latch_count got %0d want %0d", bus.latch_count, lc_model); end
  endtask
  task automatic test_disconnect();
    bus.pad_btn = 24'($urandom) & 24'h000FFF;
    bus.pad_connected = 2'b11;
    pulse_latch();
    bus.pad_connected = 2'b01;
    shift_read(12);
    for (int i = 0; i <= 12; i++) begin
      n_checks++;
      if (got[i][1] !== 1'b1) begin n_fail++; $display("FAIL disc p1 bit%0d got %b want 1", i, got[i][1]); end
      n_checks++;
      if (got[i][0] !== exp_line(exp_btn[0], i, 1'b1)) begin
        n_fail++; $display("FAIL disc p0 bit%0d got %b want %b", i, got[i][0], exp_line(exp_btn[0], i, 1'b1));
      end
    end
    bus.pad_connected = 2'b11;
  endtask
  task automatic test_reset_mid_read();
    bus.pad_btn = 24'($urandom);
    pulse_latch();
    shift_read(5);
    n_checks++;
    if (br[5] != 5) begin n_fail++; $display("FAIL rmid pre bits_read got %0d want 5", br[5]); end
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    lc_model = 0;
    n_checks++;
    if (bus.bits_read !== 4'd0) begin n_fail++; $display("FAIL rmid bits_read got %0d want 0", bus.bits_read); end
    n_checks++;
    if (bus.pad_out !== 2'b11) begin n_fail++; $display("FAIL rmid pad_out got %b want 11", bus.pad_out); end
    cyc(4);
    n_checks++;
    if (bus.pad_out !== 2'b11) begin n_fail++; $display("FAIL rmid post pad_out got %b want 11", bus.pad_out); end
    n_checks++;
    if (bus.latch_count !== 16'd0) begin n_fail++; $display("FAIL rmid latch_count got %0d want 0", bus.latch_count); end
    bus.pad_btn = 24'($urandom);
    pulse_latch();
    shift_read(12);
    for (int i = 0; i <= 12; i++)
      for (int p = 0; p < PLAYERS; p++) begin
        n_checks++;
        if (got[i][p] !== exp_line(exp_btn[p], i, 1'b1)) begin
          n_fail++; $display("FAIL rmid bit%0d p%0d got %b want %b", i, p, got[i][p], exp_line(exp_btn[p], i, 1'b1));
        end
      end
    n_checks++;
    if (dn[12] - dn[0] != 1) begin n_fail++; $display("FAIL rmid read_done count got %0d want 1", dn[12] - dn[0]); end
    n_checks++;
    if (int'(bus.latch_count) != lc_model) begin n_fail++; $display("FAIL rmid latch_count got %0d want %0d", bus.latch_count, lc_model); end
  endtask
  initial begin
    test_reset();
    test_basic_read();
    test_over_read();
    test_random_reads();
    test_latch_priority();
    test_disconnect();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
